// File: rtl/axi_mm_pkg.sv
// Shared AXI4 types, constants and payload-width helpers for the register slice.
package axi_mm_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        FWD    = 2'd1,
        FULL   = 2'd2
    } slice_mode_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // id, addr, len(8) size(3) burst(2) lock(1) cache(4) prot(3) qos(4) region(4), user
    function automatic int aw_pld_w(input int id_w, input int addr_w, input int user_w);
        return id_w + addr_w + 29 + user_w;
    endfunction

    function automatic int w_pld_w(input int data_w, input int user_w);
        return data_w + data_w / 8 + 1 + user_w;
    endfunction

    function automatic int b_pld_w(input int id_w, input int user_w);
        return id_w + 2 + user_w;
    endfunction

    function automatic int r_pld_w(input int id_w, input int data_w, input int user_w);
        return id_w + data_w + 2 + 1 + user_w;
    endfunction

endpackage

// File: rtl/axi_mm_if.sv
// AXI4 memory-mapped bundle; aresetn is carried for the system but not used by the slice.
interface axi_mm_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  aresetn;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic [3:0]            awregion;
    logic [USER_WIDTH-1:0] awuser;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic [USER_WIDTH-1:0] wuser;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic [USER_WIDTH-1:0] buser;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;
    logic [USER_WIDTH-1:0] aruser;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [USER_WIDTH-1:0] ruser;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_skid_buf.sv
// Purpose: one valid/ready channel stage, selectable as wires, forward register or two-entry skid.
// Latency: 0 cycles in BYPASS, 1 cycle in FWD and FULL.
// Backpressure: BYPASS passes ready through; FWD ready = !dst_vld || dst_rdy; FULL ready = !skid occupied.
module axi_skid_buf
    import axi_mm_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter slice_mode_e MODE  = FULL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_vld,
    output logic             src_rdy,
    input  logic [WIDTH-1:0] src_dat,
    output logic             dst_vld,
    input  logic             dst_rdy,
    output logic [WIDTH-1:0] dst_dat
);

    generate
        if (MODE == BYPASS) begin : g_bypass
            assign dst_vld = src_vld;
            assign dst_dat = src_dat;
            assign src_rdy = dst_rdy;

            logic unused_bypass;
            assign unused_bypass = clk ^ rst;
        end else if (MODE == FWD) begin : g_fwd
            logic             main_vld;
            logic [WIDTH-1:0] main_dat;

            // Reset gates both handshake sides so nothing is taken or offered while held.
            assign src_rdy = !rst && (!main_vld || dst_rdy);
            assign dst_vld = !rst && main_vld;
            assign dst_dat = main_dat;

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_vld <= 1'b0;
                end else if (src_rdy) begin
                    main_vld <= src_vld;
                end
            end

            always_ff @(posedge clk) begin
                if (src_rdy && src_vld) begin
                    main_dat <= src_dat;
                end
            end
        end else begin : g_full
            logic             main_vld;
            logic             skid_vld;
            logic [WIDTH-1:0] main_dat;
            logic [WIDTH-1:0] skid_dat;
            logic             src_hs;
            logic             dst_hs;
            logic             main_free;

            assign src_rdy   = !rst && !skid_vld;
            assign dst_vld   = !rst && main_vld;
            assign dst_dat   = main_dat;
            assign src_hs    = src_vld && src_rdy;
            assign dst_hs    = dst_vld && dst_rdy;
            assign main_free = !main_vld || dst_hs;

            // Skid is only ever occupied while main is, so refilling main prefers skid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    main_vld <= 1'b0;
                    skid_vld <= 1'b0;
                end else if (main_free) begin
                    main_vld <= skid_vld || src_hs;
                    skid_vld <= 1'b0;
                end else if (src_hs) begin
                    skid_vld <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (main_free) begin
                    main_dat <= skid_vld ? skid_dat : src_dat;
                end
                if (!main_free && src_hs) begin
                    skid_dat <= src_dat;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/axi_mm_reg_slice.sv
// Purpose: AXI4 register slice, per-channel bypass/forward/skid; AXI_MM_REG_SLICE_STATS_EN adds outstanding counters.
// Latency: 0 cycles for a bypassed channel, 1 cycle for forward or full.
// Backpressure: each channel stalls independently per its mode; no cross-channel coupling.
module axi_mm_reg_slice
    import axi_mm_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1,
    parameter int AW_MODE    = 2,
    parameter int W_MODE     = 2,
    parameter int B_MODE     = 2,
    parameter int AR_MODE    = 2,
    parameter int R_MODE     = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 aclk,
    input  logic                 areset,
    axi_mm_if.slave              s_axi,
    axi_mm_if.master             m_axi
`ifdef AXI_MM_REG_SLICE_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] wr_outstanding,
    output logic [CNT_WIDTH-1:0] rd_outstanding
`endif
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int AW_W = aw_pld_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
    localparam int W_W  = w_pld_w(DATA_WIDTH, USER_WIDTH);
    localparam int B_W  = b_pld_w(ID_WIDTH, USER_WIDTH);
    localparam int R_W  = r_pld_w(ID_WIDTH, DATA_WIDTH, USER_WIDTH);

    logic [AW_W-1:0] aw_src_dat, aw_dst_dat;
    logic [W_W-1:0]  w_src_dat,  w_dst_dat;
    logic [B_W-1:0]  b_src_dat,  b_dst_dat;
    logic [AW_W-1:0] ar_src_dat, ar_dst_dat;
    logic [R_W-1:0]  r_src_dat,  r_dst_dat;

    assign aw_src_dat = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst, s_axi.awlock,
                         s_axi.awcache, s_axi.awprot, s_axi.awqos, s_axi.awregion, s_axi.awuser};
    assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst, m_axi.awlock,
            m_axi.awcache, m_axi.awprot, m_axi.awqos, m_axi.awregion, m_axi.awuser} = aw_dst_dat;

    assign w_src_dat = {s_axi.wdata, s_axi.wstrb, s_axi.wlast, s_axi.wuser};
    assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast, m_axi.wuser} = w_dst_dat;

    assign b_src_dat = {m_axi.bid, m_axi.bresp, m_axi.buser};
    assign {s_axi.bid, s_axi.bresp, s_axi.buser} = b_dst_dat;

    assign ar_src_dat = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst, s_axi.arlock,
                         s_axi.arcache, s_axi.arprot, s_axi.arqos, s_axi.arregion, s_axi.aruser};
    assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arlock,
            m_axi.arcache, m_axi.arprot, m_axi.arqos, m_axi.arregion, m_axi.aruser} = ar_dst_dat;

    assign r_src_dat = {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast, m_axi.ruser};
    assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast, s_axi.ruser} = r_dst_dat;

    axi_skid_buf #(.WIDTH(AW_W), .MODE(slice_mode_e'(AW_MODE))) u_aw (
        .clk(aclk), .rst(areset),
        .src_vld(s_axi.awvalid), .src_rdy(s_axi.awready), .src_dat(aw_src_dat),
        .dst_vld(m_axi.awvalid), .dst_rdy(m_axi.awready), .dst_dat(aw_dst_dat)
    );

    axi_skid_buf #(.WIDTH(W_W), .MODE(slice_mode_e'(W_MODE))) u_w (
        .clk(aclk), .rst(areset),
        .src_vld(s_axi.wvalid), .src_rdy(s_axi.wready), .src_dat(w_src_dat),
        .dst_vld(m_axi.wvalid), .dst_rdy(m_axi.wready), .dst_dat(w_dst_dat)
    );

    axi_skid_buf #(.WIDTH(B_W), .MODE(slice_mode_e'(B_MODE))) u_b (
        .clk(aclk), .rst(areset),
        .src_vld(m_axi.bvalid), .src_rdy(m_axi.bready), .src_dat(b_src_dat),
        .dst_vld(s_axi.bvalid), .dst_rdy(s_axi.bready), .dst_dat(b_dst_dat)
    );

    axi_skid_buf #(.WIDTH(AW_W), .MODE(slice_mode_e'(AR_MODE))) u_ar (
        .clk(aclk), .rst(areset),
        .src_vld(s_axi.arvalid), .src_rdy(s_axi.arready), .src_dat(ar_src_dat),
        .dst_vld(m_axi.arvalid), .dst_rdy(m_axi.arready), .dst_dat(ar_dst_dat)
    );

    axi_skid_buf #(.WIDTH(R_W), .MODE(slice_mode_e'(R_MODE))) u_r (
        .clk(aclk), .rst(areset),
        .src_vld(m_axi.rvalid), .src_rdy(m_axi.rready), .src_dat(r_src_dat),
        .dst_vld(s_axi.rvalid), .dst_rdy(s_axi.rready), .dst_dat(r_dst_dat)
    );

`ifdef AXI_MM_REG_SLICE_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 aw_hs, b_hs, ar_hs, rlast_hs;
    logic [CNT_WIDTH-1:0] wr_cnt, rd_cnt;

    // Counted on the upstream side so they reflect what the master sees as open.
    assign aw_hs    = s_axi.awvalid && s_axi.awready;
    assign b_hs     = s_axi.bvalid  && s_axi.bready;
    assign ar_hs    = s_axi.arvalid && s_axi.arready;
    assign rlast_hs = s_axi.rvalid  && s_axi.rready && s_axi.rlast;

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (aw_hs && !b_hs && wr_cnt != CNT_MAX) begin
                wr_cnt <= wr_cnt + 1'b1;
            end else if (b_hs && !aw_hs && wr_cnt != '0) begin
                wr_cnt <= wr_cnt - 1'b1;
            end
            if (ar_hs && !rlast_hs && rd_cnt != CNT_MAX) begin
                rd_cnt <= rd_cnt + 1'b1;
            end else if (rlast_hs && !ar_hs && rd_cnt != '0) begin
                rd_cnt <= rd_cnt - 1'b1;
            end
        end
    end

    assign wr_outstanding = areset ? '0 : wr_cnt;
    assign rd_outstanding = areset ? '0 : rd_cnt;
`endif

endmodule

// File: tb/tb_axi_mm_reg_slice.sv
// Randomised scoreboard bench: AW forward, W/AR/R full skid, B bypass; a FIFO occupancy model predicts every output.
module tb_axi_mm_reg_slice;

    localparam int PW   = 72;
    localparam int AWW  = 4 + 32 + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + 1;
    localparam int CNTW = 3;
    localparam int CMAX = (1 << CNTW) - 1;

    function automatic int cw(input int c);
        case (c)
            0, 3:    return AWW;
            1:       return 32 + 4 + 1 + 1;
            2:       return 4 + 2 + 1;
            default: return 4 + 32 + 2 + 1 + 1;
        endcase
    endfunction

    function automatic int cmode(input int c);
        case (c)
            0:       return 1;
            2:       return 0;
            default: return 2;
        endcase
    endfunction

    function automatic string cname(input int c);
        case (c)
            0:       return "AW";
            1:       return "W";
            2:       return "B";
            3:       return "AR";
            default: return "R";
        endcase
    endfunction

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;
    logic areset;

    axi_mm_if s_if ();
    axi_mm_if m_if ();
    assign s_if.aresetn = 1'b1;
    assign m_if.aresetn = 1'b1;

    logic [4:0]    svld, drdy;
    logic [PW-1:0] sdat [5];
    wire  [4:0]    srdy, dvld;
    wire  [PW-1:0] ddat [5];

    assign s_if.awvalid = svld[0];
    assign {s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst, s_if.awlock,
            s_if.awcache, s_if.awprot, s_if.awqos, s_if.awregion, s_if.awuser} = sdat[0][AWW-1:0];
    assign m_if.awready = drdy[0];
    assign srdy[0] = s_if.awready;
    assign dvld[0] = m_if.awvalid;
    assign ddat[0] = PW'({m_if.awid, m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst, m_if.awlock,
                          m_if.awcache, m_if.awprot, m_if.awqos, m_if.awregion, m_if.awuser});

    assign s_if.wvalid = svld[1];
    assign {s_if.wdata, s_if.wstrb, s_if.wlast, s_if.wuser} = sdat[1][37:0];
    assign m_if.wready = drdy[1];
    assign srdy[1] = s_if.wready;
    assign dvld[1] = m_if.wvalid;
    assign ddat[1] = PW'({m_if.wdata, m_if.wstrb, m_if.wlast, m_if.wuser});

    assign m_if.bvalid = svld[2];
    assign {m_if.bid, m_if.bresp, m_if.buser} = sdat[2][6:0];
    assign s_if.bready = drdy[2];
    assign srdy[2] = m_if.bready;
    assign dvld[2] = s_if.bvalid;
    assign ddat[2] = PW'({s_if.bid, s_if.bresp, s_if.buser});

    assign s_if.arvalid = svld[3];
    assign {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst, s_if.arlock,
            s_if.arcache, s_if.arprot, s_if.arqos, s_if.arregion, s_if.aruser} = sdat[3][AWW-1:0];
    assign m_if.arready = drdy[3];
    assign srdy[3] = s_if.arready;
    assign dvld[3] = m_if.arvalid;
    assign ddat[3] = PW'({m_if.arid, m_if.araddr, m_if.arlen, m_if.arsize, m_if.arburst, m_if.arlock,
                          m_if.arcache, m_if.arprot, m_if.arqos, m_if.arregion, m_if.aruser});

    assign m_if.rvalid = svld[4];
    assign {m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast, m_if.ruser} = sdat[4][39:0];
    assign s_if.rready = drdy[4];
    assign srdy[4] = m_if.rready;
    assign dvld[4] = s_if.rvalid;
    assign ddat[4] = PW'({s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast, s_if.ruser});

`ifdef AXI_MM_REG_SLICE_STATS_EN
    wire [CNTW-1:0] wr_out, rd_out;
`endif

    axi_mm_reg_slice #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(1),
        .AW_MODE(1), .W_MODE(2), .B_MODE(0), .AR_MODE(2), .R_MODE(2),
        .CNT_WIDTH(CNTW)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axi(s_if),
        .m_axi(m_if)
`ifdef AXI_MM_REG_SLICE_STATS_EN
        ,
        .wr_outstanding(wr_out),
        .rd_outstanding(rd_out)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string nm, input int c,
                       input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s %s: got %h expected %h at %0t", cname(c), nm, act, exp, $time);
    endtask

    // Each channel behaves as an ordered FIFO of accepted beats.
    logic [PW-1:0] q [5][$];

    int p_vld = 0;
    int p_rdy = 0;
    bit toggle_rdy = 1'b0;

    function automatic logic [PW-1:0] rnd_pld(input int c);
        logic [95:0]   r96;
        logic [PW-1:0] m;
        r96 = {$urandom(), $urandom(), $urandom()};
        m = '0;
        for (int i = 0; i < cw(c); i++) m[i] = 1'b1;
        return r96[PW-1:0] & m;
    endfunction

    // Stimulus: master on AW/W/AR and slave-side responder on B/R.
    initial begin
        logic [4:0] hs;
        svld = '0;
        drdy = '0;
        for (int c = 0; c < 5; c++) sdat[c] = '0;
        forever begin
            @(negedge aclk);
            hs = svld & srdy;
            @(posedge aclk);
            #1;
            for (int c = 0; c < 5; c++) begin
                if (hs[c]) begin
                    if (cmode(c) != 0) q[c].push_back(sdat[c]);
                    svld[c] = 1'b0;
                end
                if (!svld[c] && $urandom_range(99) < p_vld) begin
                    svld[c] = 1'b1;
                    sdat[c] = rnd_pld(c);
                end
                drdy[c] = toggle_rdy ? ~drdy[c] : ($urandom_range(99) < p_rdy);
            end
        end
    end

    // Monitor: compares every cycle against the occupancy model.
    initial begin
        int occ;
        bit er;
        int m_wr, m_rd;
        m_wr = 0;
        m_rd = 0;
        forever begin
            @(negedge aclk);
            for (int c = 0; c < 5; c++) begin
                if (cmode(c) == 0) begin
                    chk(dvld[c] == svld[c], "bypass_vld", c, PW'(dvld[c]), PW'(svld[c]));
                    chk(ddat[c] == sdat[c], "bypass_dat", c, ddat[c], sdat[c]);
                    chk(srdy[c] == drdy[c], "bypass_rdy", c, PW'(srdy[c]), PW'(drdy[c]));
                end else if (areset) begin
                    chk(dvld[c] == 1'b0, "rst_vld", c, PW'(dvld[c]), '0);
                    chk(srdy[c] == 1'b0, "rst_rdy", c, PW'(srdy[c]), '0);
                    q[c].delete();
                end else begin
                    occ = q[c].size();
                    chk(dvld[c] == (occ > 0), "dst_vld", c, PW'(dvld[c]), PW'(occ > 0));
                    if (occ > 0 && dvld[c]) chk(ddat[c] == q[c][0], "dst_dat", c, ddat[c], q[c][0]);
                    er = (cmode(c) == 2) ? (occ < 2) : (occ == 0 || drdy[c]);
                    chk(srdy[c] == er, "src_rdy", c, PW'(srdy[c]), PW'(er));
                    if (occ > 0 && dvld[c] && drdy[c]) void'(q[c].pop_front());
                end
            end
`ifdef AXI_MM_REG_SLICE_STATS_EN
            if (areset) begin
                chk(wr_out == '0, "wr_outstanding_rst", 0, PW'(wr_out), '0);
                chk(rd_out == '0, "rd_outstanding_rst", 3, PW'(rd_out), '0);
                m_wr = 0;
                m_rd = 0;
            end else begin
                chk(int'(wr_out) == m_wr, "wr_outstanding", 0, PW'(wr_out), PW'(m_wr));
                chk(int'(rd_out) == m_rd, "rd_outstanding", 3, PW'(rd_out), PW'(m_rd));
                if ((svld[0] && srdy[0]) && !(dvld[2] && drdy[2])) m_wr = (m_wr < CMAX) ? m_wr + 1 : m_wr;
                else if (!(svld[0] && srdy[0]) && (dvld[2] && drdy[2])) m_wr = (m_wr > 0) ? m_wr - 1 : m_wr;
                if ((svld[3] && srdy[3]) && !(dvld[4] && drdy[4] && s_if.rlast)) m_rd = (m_rd < CMAX) ? m_rd + 1 : m_rd;
                else if (!(svld[3] && srdy[3]) && (dvld[4] && drdy[4] && s_if.rlast)) m_rd = (m_rd > 0) ? m_rd - 1 : m_rd;
            end
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        areset = 1'b1;
        cyc(4);
        areset = 1'b0;

        // Full-rate streaming: no bubbles expected anywhere.
        p_vld = 100; p_rdy = 100;
        cyc(40);

        // Downstream ready toggling every cycle.
        toggle_rdy = 1'b1;
        cyc(40);
        toggle_rdy = 1'b0;

        p_vld = 60; p_rdy = 50;
        cyc(300);

        // Fill every buffer against a stalled sink, then reset on top of it.
        p_vld = 100; p_rdy = 0;
        cyc(8);
        areset = 1'b1;
        cyc(3);
        areset = 1'b0;
        p_rdy = 100;
        cyc(20);

        p_vld = 70; p_rdy = 30;
        cyc(400);
        p_vld = 30; p_rdy = 80;
        cyc(400);

        p_vld = 0; p_rdy = 100;
        cyc(20);
        for (int c = 0; c < 5; c++) begin
            if (cmode(c) != 0) chk(q[c].size() == 0, "drain_empty", c, PW'(q[c].size()), '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
